// File: rtl/nfc_command_arbiter.sv
// Arbitrates the shared atom command generator between command primitives.
// The owner's request fields reach the ACG combinationally; ACG status is routed back to the owner only.
module nfc_command_arbiter #(
  parameter int          NumberOfWays  = 4,
  parameter int          NumberOfCmds  = 4,
  parameter int unsigned TimeoutCycles = 1000000
) (
  input  logic                        iSystemClock,
  input  logic                        iReset,
  input  logic [NumberOfCmds-1:0]     iCmdStart,
  input  logic [NumberOfCmds-1:0]     iCmdLastStep,
  input  logic [8*NumberOfCmds-1:0]   iCmdACG_Command,
  input  logic [3*NumberOfCmds-1:0]   iCmdACG_CommandOption,
  input  logic [NumberOfWays*NumberOfCmds-1:0] iCmdACG_TargetWay,
  input  logic [16*NumberOfCmds-1:0]  iCmdACG_NumOfData,
  input  logic [NumberOfCmds-1:0]     iCmdACG_CASelect,
  input  logic [40*NumberOfCmds-1:0]  iCmdACG_CAData,
  output logic [7:0]                  oACG_Command,
  output logic [2:0]                  oACG_CommandOption,
  output logic [NumberOfWays-1:0]     oACG_TargetWay,
  output logic [15:0]                 oACG_NumOfData,
  output logic                        oACG_CASelect,
  output logic [39:0]                 oACG_CAData,
  input  logic [7:0]                  iACG_Ready,
  input  logic [7:0]                  iACG_LastStep,
  output logic [8*NumberOfCmds-1:0]   oCmdACG_Ready,
  output logic [8*NumberOfCmds-1:0]   oCmdACG_LastStep,
  output logic                        oCMDReady,
  output logic [NumberOfCmds-1:0]     oOwner,
  output logic                        oLastStep,
  output logic                        oTimeout,
  output logic                        oConflict
);

  // state   | meaning
  // IDLE    | no owner, accepting a start pulse
  // OWNED   | one primitive drives the ACG; waiting for its last step or timeout
  // RELEASE | one-cycle gap before the next grant
  typedef enum logic [2:0] {
    S_IDLE    = 3'b001,
    S_OWNED   = 3'b010,
    S_RELEASE = 3'b100
  } state_e;

  localparam bit          TimeoutEn   = (TimeoutCycles != 0);
  localparam logic [31:0] TimeoutLast = (TimeoutCycles == 0) ? 32'd0 : 32'(TimeoutCycles - 1);

  state_e                  state_q, state_d;
  logic [NumberOfCmds-1:0] owner_q, owner_d;
  logic [31:0]             counter_q, counter_d;
  logic                    timeout_q, timeout_d;
  logic                    conflict_q, conflict_d;
  logic                    last_step_q, last_step_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic [NumberOfCmds-1:0] start_lowest;
  logic                    start_multi;

  assign start_lowest = iCmdStart & (~iCmdStart + NumberOfCmds'(1));
  assign start_multi  = |(iCmdStart & (iCmdStart - NumberOfCmds'(1)));

  always_ff @(posedge iSystemClock or negedge iReset) begin
    if (!iReset) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      counter_q   <= '0;
      timeout_q   <= 1'b0;
      conflict_q  <= 1'b0;
      last_step_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      counter_q   <= counter_d;
      timeout_q   <= timeout_d;
      conflict_q  <= conflict_d;
      last_step_q <= last_step_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    counter_d   = counter_q;
    timeout_d   = timeout_q;
    conflict_d  = conflict_q;
    last_step_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|iCmdStart) begin
          state_d    = S_OWNED;
          owner_d    = start_lowest;
          counter_d  = '0;
          timeout_d  = 1'b0;
          conflict_d = start_multi;
        end
      end
      S_OWNED: begin
        if (counter_q != '1) counter_d = counter_q + 32'd1;
        // Owner completion takes priority over a coincident timeout.
        if (|(iCmdLastStep & owner_q)) begin
          state_d     = S_RELEASE;
          owner_d     = '0;
          last_step_d = 1'b1;
        end else if (TimeoutEn && (counter_q == TimeoutLast)) begin
          state_d   = S_RELEASE;
          owner_d   = '0;
          timeout_d = 1'b1;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        owner_d = '0;
      end
    endcase
    cmd_ready_d = (state_d == S_IDLE);
  end

  // owner_q is zero outside OWNED, so the idle values fall out of the defaults.
  always_comb begin
    oACG_Command       = '0;
    oACG_CommandOption = '0;
    oACG_TargetWay     = '0;
    oACG_NumOfData     = '0;
    oACG_CASelect      = 1'b1;
    oACG_CAData        = '0;
    oCmdACG_Ready      = '0;
    oCmdACG_LastStep   = '0;
    for (int k = 0; k < NumberOfCmds; k++) begin
      if (owner_q[k]) begin
        oACG_Command                = iCmdACG_Command[8*k +: 8];
        oACG_CommandOption          = iCmdACG_CommandOption[3*k +: 3];
        oACG_TargetWay              = iCmdACG_TargetWay[NumberOfWays*k +: NumberOfWays];
        oACG_NumOfData              = iCmdACG_NumOfData[16*k +: 16];
        oACG_CASelect               = iCmdACG_CASelect[k];
        oACG_CAData                 = iCmdACG_CAData[40*k +: 40];
        oCmdACG_Ready[8*k +: 8]     = iACG_Ready;
        oCmdACG_LastStep[8*k +: 8]  = iACG_LastStep;
      end
    end
  end

  assign oCMDReady = cmd_ready_q;
  assign oOwner    = owner_q;
  assign oLastStep = last_step_q;
  assign oTimeout  = timeout_q;
  assign oConflict = conflict_q;

endmodule

// File: tb/tb_nfc_command_arbiter.sv
// Directed bench for nfc_command_arbiter: a grant-level model checked every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_nfc_command_arbiter;
  localparam int NC = 4;
  localparam int NW = 4;
  localparam int TO = 16;

  logic             clk;
  logic             rst_n;
  logic [NC-1:0]    start, cmd_last;
  logic [8*NC-1:0]  cmd;
  logic [3*NC-1:0]  opt;
  logic [NW*NC-1:0] way;
  logic [16*NC-1:0] ndata;
  logic [NC-1:0]    casel;
  logic [40*NC-1:0] cadata;
  logic [7:0]       acg_rdy, acg_last;
  logic [7:0]       o_cmd;
  logic [2:0]       o_opt;
  logic [NW-1:0]    o_way;
  logic [15:0]      o_ndata;
  logic             o_casel;
  logic [39:0]      o_cadata;
  logic [8*NC-1:0]  o_rdy, o_last;
  logic             o_cmdready, o_laststep, o_timeout, o_conflict;
  logic [NC-1:0]    o_owner;

  int checks = 0;
  int errors = 0;

  nfc_command_arbiter #(.NumberOfWays(NW), .NumberOfCmds(NC), .TimeoutCycles(TO)) dut (
    .iSystemClock(clk), .iReset(rst_n),
    .iCmdStart(start), .iCmdLastStep(cmd_last),
    .iCmdACG_Command(cmd), .iCmdACG_CommandOption(opt), .iCmdACG_TargetWay(way),
    .iCmdACG_NumOfData(ndata), .iCmdACG_CASelect(casel), .iCmdACG_CAData(cadata),
    .oACG_Command(o_cmd), .oACG_CommandOption(o_opt), .oACG_TargetWay(o_way),
    .oACG_NumOfData(o_ndata), .oACG_CASelect(o_casel), .oACG_CAData(o_cadata),
    .iACG_Ready(acg_rdy), .iACG_LastStep(acg_last),
    .oCmdACG_Ready(o_rdy), .oCmdACG_LastStep(o_last),
    .oCMDReady(o_cmdready), .oOwner(o_owner), .oLastStep(o_laststep),
    .oTimeout(o_timeout), .oConflict(o_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_idx(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Grant-level model: who owns the ACG, how long they have held it, and why the last grant ended.
  int   m_owner;
  int   m_age;
  logic m_release, m_last, m_timeout, m_conflict;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1; m_age <= 0; m_release <= 1'b0;
      m_last <= 1'b0; m_timeout <= 1'b0; m_conflict <= 1'b0;
    end else if (m_release) begin
      m_release <= 1'b0;
      m_last    <= 1'b0;
    end else if (m_owner < 0) begin
      if (start != '0) begin
        m_owner    <= lowest_idx(start);
        m_age      <= 0;
        m_conflict <= ($countones(start) > 1);
        m_timeout  <= 1'b0;
      end
    end else if (cmd_last[m_owner]) begin
      m_owner <= -1; m_release <= 1'b1; m_last <= 1'b1;
    end else if (m_age + 1 == TO) begin
      m_owner <= -1; m_release <= 1'b1; m_timeout <= 1'b1;
    end else begin
      m_age <= m_age + 1;
    end
  end

  logic [71:0]     exp_acg;
  logic [8*NC-1:0] exp_rdy, exp_last;
  logic [NC-1:0]   exp_owner;
  always_comb begin
    exp_acg   = {8'h00, 3'b000, {NW{1'b0}}, 16'h0000, 1'b1, 40'h0};
    exp_rdy   = '0;
    exp_last  = '0;
    exp_owner = '0;
    if (m_owner >= 0) begin
      exp_acg = {cmd[8*m_owner +: 8], opt[3*m_owner +: 3], way[NW*m_owner +: NW],
                 ndata[16*m_owner +: 16], casel[m_owner], cadata[40*m_owner +: 40]};
      exp_rdy[8*m_owner +: 8]  = acg_rdy;
      exp_last[8*m_owner +: 8] = acg_last;
      exp_owner[m_owner]       = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("acg_fields", {o_cmd, o_opt, o_way, o_ndata, o_casel, o_cadata}, exp_acg);
      check("status_ready", o_rdy, exp_rdy);
      check("status_last", o_last, exp_last);
      check("owner", o_owner, exp_owner);
      check("cmd_ready", o_cmdready, (m_owner < 0) && !m_release);
      check("last_pulse", o_laststep, m_last);
      check("timeout_flag", o_timeout, m_timeout);
      check("conflict_flag", o_conflict, m_conflict);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = '0; cmd_last = '0;
    cmd    = 32'h31_40_12_01;
    opt    = 12'b101_011_110_001;
    way    = 16'h8421;
    ndata  = 64'hAAAA_1234_5678_0001;
    casel  = 4'b0101;
    cadata = {40'h1111111111, 40'hff00000000, 40'h2222222222, 40'h3333333333};
    acg_rdy = 8'hA5; acg_last = 8'h00;

    @(negedge clk);
    check("rst_cmd_ready", o_cmdready, 1'b1);
    check("rst_owner", o_owner, 4'b0000);
    check("rst_casel", o_casel, 1'b1);
    check("rst_command", o_cmd, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(2);

    // Single request from primitive 2
    start = 4'b0100;
    tick(1);
    start = '0;
    @(negedge clk);
    check("grant2_owner", o_owner, 4'b0100);
    check("grant2_cmd_ready", o_cmdready, 1'b0);
    check("grant2_cadata", o_cadata, 40'hff00000000);
    check("grant2_command", o_cmd, 8'h40);
    check("grant2_ready_route", o_rdy, 32'h00A5_0000);
    @(posedge clk); #1;
    acg_last = 8'h40;
    #1 check("grant2_last_route", o_last, 32'h0040_0000);
    tick(1);
    acg_last = 8'h00;
    cmd_last = 4'b0001;
    tick(1);
    cmd_last = 4'b0100;
    tick(1);
    cmd_last = '0;
    @(negedge clk);
    check("rel2_last_pulse", o_laststep, 1'b1);
    check("rel2_owner", o_owner, 4'b0000);
    check("rel2_cmd_ready", o_cmdready, 1'b0);
    check("rel2_command", o_cmd, 8'h00);
    @(negedge clk);
    check("idle_last_pulse", o_laststep, 1'b0);
    check("idle_cmd_ready", o_cmdready, 1'b1);
    check("idle_casel", o_casel, 1'b1);

    // Conflicting request, then timeout of primitive 1
    @(posedge clk); #1;
    start = 4'b0110;
    tick(1);
    start = '0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_owner == '0) break;
      n++;
      if (n == 1) begin
        check("conf_owner", o_owner, 4'b0010);
        check("conf_flag", o_conflict, 1'b1);
      end
    end
    check("timeout_owned_cycles", n, 16);
    check("timeout_set", o_timeout, 1'b1);
    check("timeout_no_last", o_laststep, 1'b0);

    // New grant clears sticky flags; last step coincides with the timeout cycle
    @(posedge clk); #1;
    start = 4'b1000;
    tick(1);
    start = '0;
    @(negedge clk);
    check("grant3_timeout_clr", o_timeout, 1'b0);
    check("grant3_conflict_clr", o_conflict, 1'b0);
    check("grant3_owner", o_owner, 4'b1000);
    @(posedge clk); #1;
    tick(5);
    start = 4'b0001;
    tick(1);
    start = '0;
    tick(8);
    cmd_last = 4'b1000;
    tick(1);
    cmd_last = '0;
    @(negedge clk);
    check("tie_last_pulse", o_laststep, 1'b1);
    check("tie_no_timeout", o_timeout, 1'b0);
    check("tie_owner", o_owner, 4'b0000);

    // Reset in the middle of a grant
    @(posedge clk); #1;
    start = 4'b0001;
    tick(1);
    start = '0;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_owner", o_owner, 4'b0000);
    check("midrst_command", o_cmd, 8'h00);
    check("midrst_casel", o_casel, 1'b1);
    check("midrst_ready_route", o_rdy, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("postrst_cmd_ready", o_cmdready, 1'b1);

    // Owner 0 with changing fields and status while owned
    @(posedge clk); #1;
    start = 4'b0001;
    tick(1);
    start = '0;
    for (int i = 0; i < 4; i++) begin
      cmd[7:0]    = 8'(8'h5A + i);
      cadata[39:0] = {8'(i), 32'hDEAD_BEEF};
      acg_rdy     = 8'($urandom_range(0, 255));
      acg_last    = 8'($urandom_range(0, 255));
      tick(1);
    end
    cmd_last = 4'b0001;
    tick(1);
    cmd_last = '0;
    acg_last = 8'h00;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
